// File: rtl/cache_bus_pkg.sv
// Shared types for the cache bus arbiter.
//   arb_state_t : arbiter FSM states
//   bus_cmd_t   : latched downstream command (store bit, line address, requester id)
// The struct is sized for the widest supported configuration. Users cast down
// to their own ADDR_WIDTH / id width.
package cache_bus_pkg;

   localparam int unsigned MAX_ADDR_WIDTH = 64;
   localparam int unsigned MAX_ID_WIDTH   = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   typedef struct packed {
      logic                      store;
      logic [MAX_ADDR_WIDTH-1:0] addr;
      logic [MAX_ID_WIDTH-1:0]   id;
   } bus_cmd_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder.
//   req : request vector
//   ptr : index holding highest priority (must be < N)
//   any : at least one request set
//   idx : first set request at or after ptr, wrapping modulo N
module rr_pick #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   logic [N-1:0] rot;

   always_comb begin
      int unsigned sum;
      // Rotate so that bit 0 of rot is the requester at ptr.
      rot = N'({req, req} >> ptr);
      any = 1'b0;
      idx = '0;
      sum = 0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!any && rot[k]) begin
            any = 1'b1;
            sum = 32'(ptr) + k;
            if (sum >= N) sum = sum - N;
            idx = IW'(sum);
         end
      end
   end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one cache<->memory bus engine between CONNECTIONS caches.
// Accepts one request at a time: round-robin, with an aging override.
// Issues it to the engine, then holds the grant until the engine completes
// and the requester takes the response.
// Ports:
//   clk, reset                   clock, async active-high reset
//   req_valid/store/addr         per-requester command (addr packed i*ADDR_WIDTH)
//   req_ready                    one-hot accept pulse
//   rsp_valid / rsp_ready        one-hot completion handshake
//   eng_cmd_valid/store/addr/id  command to bus engine
//   eng_cmd_ready                engine accepts command
//   eng_done                     engine finished transaction (1-cycle pulse)
//   busy                         arbiter not idle
module cache_bus_arbiter
   import cache_bus_pkg::*;
#(
   parameter int unsigned CONNECTIONS = 2,
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned AGE_MAX     = 15,
   localparam int unsigned IW = (CONNECTIONS > 1) ? $clog2(CONNECTIONS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [CONNECTIONS-1:0]            req_valid,
   input  logic [CONNECTIONS-1:0]            req_store,
   input  logic [CONNECTIONS*ADDR_WIDTH-1:0] req_addr,
   output logic [CONNECTIONS-1:0]            req_ready,
   output logic [CONNECTIONS-1:0]            rsp_valid,
   input  logic [CONNECTIONS-1:0]            rsp_ready,
   output logic                              eng_cmd_valid,
   output logic                              eng_cmd_store,
   output logic [ADDR_WIDTH-1:0]             eng_cmd_addr,
   output logic [IW-1:0]                     eng_cmd_id,
   input  logic                              eng_cmd_ready,
   input  logic                              eng_done,
   output logic                              busy
);

   localparam int unsigned AGEW = $clog2(AGE_MAX + 1);

   arb_state_t state, state_next;
   bus_cmd_t   cmd_q;

   logic [IW-1:0]          rr_ptr, win, aged_idx, rr_idx, gnt_id;
   logic                   aged_any, rr_any, accept;
   logic [CONNECTIONS-1:0] aged;
   logic [AGEW-1:0]        age      [CONNECTIONS];
   logic [ADDR_WIDTH-1:0]  addr_arr [CONNECTIONS];

   always_comb begin
      for (int unsigned i = 0; i < CONNECTIONS; i++) begin
         // Masked with req_valid: age still shows AGE_MAX in the cycle a request drops.
         aged[i]     = req_valid[i] && (age[i] == AGEW'(AGE_MAX));
         addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   rr_pick #(.N(CONNECTIONS), .IW(IW)) u_aged_pick (
      .req (aged),
      .ptr ({IW{1'b0}}),
      .any (aged_any),
      .idx (aged_idx)
   );

   rr_pick #(.N(CONNECTIONS), .IW(IW)) u_rr_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .any (rr_any),
      .idx (rr_idx)
   );

   assign win    = aged_any ? aged_idx : rr_idx;
   assign accept = !reset && (state == IDLE) && rr_any;
   assign gnt_id = IW'(cmd_q.id);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         rr_ptr <= '0;
         cmd_q  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            cmd_q.store <= req_store[win];
            cmd_q.addr  <= MAX_ADDR_WIDTH'(addr_arr[win]);
            cmd_q.id    <= MAX_ID_WIDTH'(win);
            rr_ptr      <= (32'(win) == CONNECTIONS - 1) ? '0 : win + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < CONNECTIONS; i++) age[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < CONNECTIONS; i++) begin
            if (!req_valid[i] || req_ready[i]) age[i] <= '0;
            else if (age[i] != AGEW'(AGE_MAX)) age[i] <= age[i] + 1'b1;
         end
      end
   end

   always_comb begin
      state_next    = state;
      req_ready     = '0;
      rsp_valid     = '0;
      eng_cmd_valid = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               req_ready[win] = 1'b1;
               state_next     = ISSUE;
            end
         end
         ISSUE: begin
            eng_cmd_valid = 1'b1;
            if (eng_cmd_ready) state_next = WAIT;
         end
         WAIT: begin
            if (eng_done) state_next = RESP;
         end
         RESP: begin
            rsp_valid[gnt_id] = 1'b1;
            if (rsp_ready[gnt_id]) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign eng_cmd_store = cmd_q.store;
   assign eng_cmd_addr  = ADDR_WIDTH'(cmd_q.addr);
   assign eng_cmd_id    = gnt_id;
   assign busy          = (state != IDLE);

   // A done outside WAIT (including with eng_cmd_ready in ISSUE) is dropped.
   a_done_in_wait: assert property (@(posedge clk) disable iff (reset)
      eng_done |-> (state == WAIT));

   for (genvar g = 0; g < CONNECTIONS; g++) begin : g_hold
      a_req_hold: assert property (@(posedge clk) disable iff (reset)
         (req_valid[g] && !req_ready[g]) |=>
            (req_valid[g] && $stable(req_store[g]) &&
             $stable(req_addr[g*ADDR_WIDTH +: ADDR_WIDTH])));
   end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter (4 requesters, AGE_MAX=3).
// A transaction-level model predicts every output each cycle. Directed
// sequences pin key values with literals, then a randomized run follows.
module tb_cache_bus_arbiter;

   localparam int N       = 4;
   localparam int AW      = 64;
   localparam int AGE_MAX = 3;
   localparam int IW      = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid, req_store, req_ready, rsp_valid, rsp_ready;
   logic [N*AW-1:0] req_addr;
   logic            eng_cmd_valid, eng_cmd_store, eng_cmd_ready, eng_done, busy;
   logic [AW-1:0]   eng_cmd_addr;
   logic [IW-1:0]   eng_cmd_id;

   always #5 clk = ~clk;

   cache_bus_arbiter #(.CONNECTIONS(N), .ADDR_WIDTH(AW), .AGE_MAX(AGE_MAX)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_store     (req_store),
      .req_addr      (req_addr),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .eng_cmd_valid (eng_cmd_valid),
      .eng_cmd_store (eng_cmd_store),
      .eng_cmd_addr  (eng_cmd_addr),
      .eng_cmd_id    (eng_cmd_id),
      .eng_cmd_ready (eng_cmd_ready),
      .eng_done      (eng_done),
      .busy          (busy)
   );

   int checks = 0;
   int errors = 0;

   // Requester side: pending commands held until accepted.
   bit            pend   [N];
   bit            pstore [N];
   logic [AW-1:0] paddr  [N];

   // Transaction model: at most one transaction owns the engine.
   bit            m_have, m_cmd_out, m_done, m_store;
   logic [AW-1:0] m_addr;
   int            m_id, m_rr;
   int            m_age [N];
   logic [N-1:0]  e_ready;
   int            e_win;

   // Engine / responder timing knobs.
   int phase_cnt, ready_lat, done_lat, rsp_lat;
   bit rand_mode;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int phase();
      if (!m_have) return 0;
      if (m_cmd_out) return 1;
      if (!m_done) return 2;
      return 3;
   endfunction

   function automatic bit quiet();
      bit q = !m_have;
      for (int i = 0; i < N; i++) if (pend[i]) q = 0;
      return q;
   endfunction

   task automatic model_init();
      m_have = 0; m_cmd_out = 0; m_done = 0; m_store = 0;
      m_addr = '0; m_id = 0; m_rr = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
   endtask

   task automatic raise(input int i, input bit st, input logic [AW-1:0] a);
      pend[i] = 1; pstore[i] = st; paddr[i] = a;
   endtask

   // Drive inputs, then compare all outputs against the model.
   task automatic eval();
      logic [N-1:0] e_rsp;
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = pend[i];
         req_store[i]          = pstore[i];
         req_addr[i*AW +: AW]  = paddr[i];
      end
      if (reset) begin
         eng_cmd_ready = 0; eng_done = 0; rsp_ready = '0;
      end else begin
         eng_cmd_ready = m_have && m_cmd_out && (phase_cnt >= ready_lat);
         eng_done      = m_have && !m_cmd_out && !m_done && (phase_cnt >= done_lat);
         rsp_ready     = rand_mode ? N'($urandom) : '0;
         if (m_done)
            for (int i = 0; i < N; i++) if (i == m_id) rsp_ready[i] = (phase_cnt >= rsp_lat);
      end
      #1;
      e_win = -1;
      e_ready = '0;
      e_rsp = '0;
      if (!reset) begin
         if (!m_have) begin
            for (int i = 0; i < N; i++)
               if (e_win < 0 && pend[i] && m_age[i] == AGE_MAX) e_win = i;
            for (int k = 0; k < N; k++)
               if (e_win < 0 && pend[(m_rr + k) % N]) e_win = (m_rr + k) % N;
         end
         for (int i = 0; i < N; i++) begin
            e_ready[i] = (i == e_win);
            e_rsp[i]   = m_have && m_done && (i == m_id);
         end
      end
      chk("req_ready",     64'(req_ready),     64'(e_ready));
      chk("rsp_valid",     64'(rsp_valid),     64'(e_rsp));
      chk("eng_cmd_valid", 64'(eng_cmd_valid), 64'(!reset && m_have && m_cmd_out));
      chk("busy",          64'(busy),          64'(!reset && m_have));
      chk("eng_cmd_store", 64'(eng_cmd_store), 64'(reset ? 1'b0 : m_store));
      chk("eng_cmd_addr",  64'(eng_cmd_addr),  reset ? 64'h0 : 64'(m_addr));
      chk("eng_cmd_id",    64'(eng_cmd_id),    reset ? 64'h0 : 64'(m_id));
   endtask

   // Step the model with this cycle's inputs, then cross the clock edge.
   task automatic advance();
      int ph_old = phase();
      if (reset) begin
         model_init();
      end else begin
         if (e_win >= 0) begin
            m_have = 1; m_cmd_out = 1; m_done = 0;
            m_store = pstore[e_win]; m_addr = paddr[e_win]; m_id = e_win;
            m_rr = (e_win + 1) % N;
            if (rand_mode) begin
               ready_lat = $urandom_range(0, 3);
               done_lat  = $urandom_range(0, 4);
               rsp_lat   = $urandom_range(0, 2);
            end
         end else if (m_have && m_cmd_out && eng_cmd_ready) begin
            m_cmd_out = 0;
         end else if (m_have && !m_cmd_out && !m_done && eng_done) begin
            m_done = 1;
         end else if (m_have && m_done && rsp_ready[m_id]) begin
            m_have = 0; m_done = 0;
         end
         for (int i = 0; i < N; i++) begin
            if (!pend[i] || e_ready[i]) m_age[i] = 0;
            else if (m_age[i] < AGE_MAX) m_age[i]++;
            if (e_ready[i]) pend[i] = 0;
         end
      end
      phase_cnt = (phase() == ph_old) ? phase_cnt + 1 : 0;
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_quiet(input int budget);
      int n = 0;
      while (!quiet() && n < budget) begin
         eval();
         advance();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d cycles required<%0d", n, budget);
      end
   endtask

   initial begin
      reset = 1; req_valid = '0; req_store = '0; req_addr = '0;
      rsp_ready = '0; eng_cmd_ready = 0; eng_done = 0;
      for (int i = 0; i < N; i++) begin pend[i] = 0; pstore[i] = 0; paddr[i] = '0; end
      model_init();
      phase_cnt = 0; ready_lat = 0; done_lat = 0; rsp_lat = 0; rand_mode = 0;
      e_win = -1; e_ready = '0;

      // Power-on reset.
      eval();
      chk("lit_reset_busy", 64'(busy), 64'h0);
      chk("lit_reset_cmd_valid", 64'(eng_cmd_valid), 64'h0);
      advance();
      reset = 0;

      // Single load from requester 1.
      raise(1, 1'b0, 64'h1000);
      eval();
      chk("lit_load_req_ready", 64'(req_ready), 64'h2);
      advance();
      eval();
      chk("lit_load_cmd_valid", 64'(eng_cmd_valid), 64'h1);
      chk("lit_load_cmd_addr", 64'(eng_cmd_addr), 64'h1000);
      chk("lit_load_cmd_id", 64'(eng_cmd_id), 64'h1);
      chk("lit_load_cmd_store", 64'(eng_cmd_store), 64'h0);
      advance();
      eval();
      advance();
      eval();
      chk("lit_load_rsp_valid", 64'(rsp_valid), 64'h2);
      advance();
      eval();
      chk("lit_load_idle", 64'(busy), 64'h0);
      advance();

      // Backpressure: engine stalls 5 cycles, requester stalls 3.
      ready_lat = 5; rsp_lat = 3;
      raise(0, 1'b0, 64'h3000);
      eval();
      chk("lit_bp_req_ready", 64'(req_ready), 64'h1);
      advance();
      for (int k = 0; k < 5; k++) begin
         eval();
         chk("lit_bp_cmd_valid", 64'(eng_cmd_valid), 64'h1);
         chk("lit_bp_cmd_addr", 64'(eng_cmd_addr), 64'h3000);
         advance();
      end
      eval(); advance();
      eval(); advance();
      for (int k = 0; k < 3; k++) begin
         eval();
         chk("lit_bp_rsp_hold", 64'(rsp_valid), 64'h1);
         advance();
      end
      eval();
      advance();
      ready_lat = 0; rsp_lat = 0;

      // Store path from requester 0.
      raise(0, 1'b1, 64'h2040);
      eval();
      chk("lit_store_req_ready", 64'(req_ready), 64'h1);
      advance();
      eval();
      chk("lit_store_cmd_store", 64'(eng_cmd_store), 64'h1);
      chk("lit_store_cmd_id", 64'(eng_cmd_id), 64'h0);
      chk("lit_store_cmd_addr", 64'(eng_cmd_addr), 64'h2040);
      advance();
      run_until_quiet(20);

      // Reset while the engine is working.
      done_lat = 10;
      raise(2, 1'b0, 64'h4000);
      eval(); advance();
      eval(); advance();
      eval(); advance();
      reset = 1;
      eval();
      chk("lit_midwait_busy", 64'(busy), 64'h0);
      chk("lit_midwait_cmd_valid", 64'(eng_cmd_valid), 64'h0);
      chk("lit_midwait_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("lit_midwait_cmd_addr", 64'(eng_cmd_addr), 64'h0);
      advance();
      reset = 0;
      done_lat = 0;
      // Fresh requests 1 and 3: a cleared pointer makes 1 win.
      raise(1, 1'b0, 64'h5000);
      raise(3, 1'b1, 64'h6000);
      eval();
      chk("lit_recover_req_ready", 64'(req_ready), 64'h2);
      advance();
      run_until_quiet(50);

      // Aging: 0 and 3 wait through a whole transaction; the pointer favours 3
      // but both saturate and the lowest aged index wins.
      raise(2, 1'b0, 64'h7000);
      eval(); advance();
      raise(0, 1'b0, 64'h8000);
      raise(3, 1'b0, 64'h9000);
      eval(); advance();
      eval(); advance();
      eval(); advance();
      eval();
      chk("lit_aging_req_ready", 64'(req_ready), 64'h1);
      advance();
      run_until_quiet(50);

      // Randomized traffic with occasional resets.
      rand_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0)
               raise(i, 1'($urandom_range(0, 1)), {$urandom, $urandom});
         reset = ($urandom_range(0, 399) == 0);
         eval();
         advance();
      end
      reset = 0;
      run_until_quiet(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
